// File: rtl/bus_pkg.sv
// Shared types and defaults for the gated bus driver (bus_gate_arbiter and its picker).
package bus_pkg;

   localparam int BUS_WIDTH_DEFAULT = 16;
   localparam int BUS_NSRC_DEFAULT  = 4;
   localparam int BUS_CNT_W_DEFAULT = 8;

   typedef logic [$clog2(BUS_NSRC_DEFAULT)-1:0] bus_sel_t;

   typedef enum logic {
      BUS_FIXED = 1'b0,
      BUS_RR    = 1'b1
   } bus_mode_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational first-set picker: searches req upward from start, wrapping NSRC-1 -> 0.
module rr_priority_pick #(
   parameter int NSRC  = 4,
   parameter int SEL_W = $clog2(NSRC)
) (
   input  logic [NSRC-1:0]  req,
   input  logic [SEL_W-1:0] start,
   output logic             found,
   output logic [SEL_W-1:0] index
);

   // Doubling the vector turns the wrap-around search into a plain shift.
   logic [2*NSRC-1:0] rot;
   logic [SEL_W:0]    pos;

   always_comb begin
      found = 1'b0;
      index = '0;
      pos   = '0;
      rot   = {req, req} >> start;
      for (int k = 0; k < NSRC; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            pos   = {1'b0, start} + (SEL_W+1)'(k);
            if (pos >= (SEL_W+1)'(NSRC)) begin
               pos = pos - (SEL_W+1)'(NSRC);
            end
            index = pos[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/bus_gate_arbiter.sv
// Registered bus driver selecting one of NSRC gated sources (fixed priority or round-robin).
// Optional conflict counter/sticky flag enabled by defining BUS_CONFLICT_LOG_EN.
module bus_gate_arbiter
   import bus_pkg::*;
#(
   parameter int WIDTH     = BUS_WIDTH_DEFAULT,
   parameter int NSRC      = BUS_NSRC_DEFAULT,
   parameter int HOLD_IDLE = 0,
   parameter int CNT_W     = BUS_CNT_W_DEFAULT
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic [NSRC-1:0]              gate,
   input  logic [NSRC-1:0][WIDTH-1:0]   src_data,
   input  logic                         rr_mode,
   output logic [WIDTH-1:0]             Bus_out,
   output logic                         bus_valid,
   output logic [$clog2(NSRC)-1:0]      sel_idx,
   output logic                         conflict,
   input  logic                         conflict_clr,
   output logic [CNT_W-1:0]             conflict_cnt,
   output logic                         conflict_stky
);

   localparam int SEL_W = $clog2(NSRC);

   // bus_valid qualifies Bus_out for exactly one cycle; there is no backpressure on the bus.
   bus_mode_e        mode;
   logic             fx_found, rr_found, grant_found, multi;
   logic [SEL_W-1:0] fx_idx, rr_idx, grant_idx, rr_next;
   logic [SEL_W-1:0] rr_ptr;

   assign mode = bus_mode_e'(rr_mode);

   rr_priority_pick #(.NSRC(NSRC)) u_fixed_pick (
      .req   (gate),
      .start (SEL_W'(0)),
      .found (fx_found),
      .index (fx_idx)
   );

   rr_priority_pick #(.NSRC(NSRC)) u_rr_pick (
      .req   (gate),
      .start (rr_ptr),
      .found (rr_found),
      .index (rr_idx)
   );

   always_comb begin
      grant_found = fx_found;
      grant_idx   = fx_idx;
      if (mode == BUS_RR) begin
         grant_found = rr_found;
         grant_idx   = rr_idx;
      end
      rr_next = (grant_idx == SEL_W'(NSRC-1)) ? '0 : grant_idx + SEL_W'(1);
      multi   = ($countones(gate) > 1);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         Bus_out   <= '0;
         bus_valid <= 1'b0;
         sel_idx   <= '0;
         conflict  <= 1'b0;
         rr_ptr    <= '0;
      end else begin
         conflict <= multi;
         if (grant_found) begin
            Bus_out   <= src_data[grant_idx];
            bus_valid <= 1'b1;
            sel_idx   <= grant_idx;
            if (mode == BUS_RR) begin
               rr_ptr <= rr_next;
            end
         end else begin
            bus_valid <= 1'b0;
            if (HOLD_IDLE == 0) begin
               Bus_out <= '0;
            end
         end
      end
   end

`ifdef BUS_CONFLICT_LOG_EN
   logic [CNT_W-1:0] cnt_q;
   logic             stky_q;

   // Clear beats a conflict landing on the same edge.
   always_ff @(posedge Clk) begin
      if (Reset || conflict_clr) begin
         cnt_q  <= '0;
         stky_q <= 1'b0;
      end else if (multi) begin
         if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         stky_q <= 1'b1;
      end
   end

   assign conflict_cnt  = cnt_q;
   assign conflict_stky = stky_q;
`else
   logic unused_conflict_clr;
   assign unused_conflict_clr = conflict_clr;
   assign conflict_cnt        = '0;
   assign conflict_stky       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Self-checking bench for bus_gate_arbiter: two instances (HOLD_IDLE 0 and 1) share stimulus.
module tb_bus_gate_arbiter;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int CW = 2;

   logic                 Clk;
   logic                 Reset;
   logic [N-1:0]         gate;
   logic [N-1:0][W-1:0]  src;
   logic                 rr_mode;
   logic                 conflict_clr;

   logic [W-1:0]  bus0, bush;
   logic          valid0, validh, conf0, confh, stky0, stkyh;
   logic [1:0]    sel0, selh;
   logic [CW-1:0] cnt0, cnth;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [W-1:0] m_bus, m_bus_h;
   logic         m_valid, m_conf, m_stky;
   int           m_sel, m_ptr, m_cnt;

   bus_gate_arbiter #(.WIDTH(W), .NSRC(N), .HOLD_IDLE(0), .CNT_W(CW)) dut (
      .Clk(Clk), .Reset(Reset), .gate(gate), .src_data(src), .rr_mode(rr_mode),
      .Bus_out(bus0), .bus_valid(valid0), .sel_idx(sel0), .conflict(conf0),
      .conflict_clr(conflict_clr), .conflict_cnt(cnt0), .conflict_stky(stky0)
   );

   bus_gate_arbiter #(.WIDTH(W), .NSRC(N), .HOLD_IDLE(1), .CNT_W(CW)) dut_h (
      .Clk(Clk), .Reset(Reset), .gate(gate), .src_data(src), .rr_mode(rr_mode),
      .Bus_out(bush), .bus_valid(validh), .sel_idx(selh), .conflict(confh),
      .conflict_clr(conflict_clr), .conflict_cnt(cnth), .conflict_stky(stkyh)
   );

   wire [22:0] obs0 = {bus0, valid0, sel0, conf0, cnt0, stky0};
   wire [22:0] obsh = {bush, validh, selh, confh, cnth, stkyh};

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic logic [22:0] exp_vec(input logic [W-1:0] b);
      return {b, m_valid, 2'(m_sel), m_conf, 2'(m_cnt), m_stky};
   endfunction

   // One clock: model consumes the inputs sampled at the edge, outputs settle by +1.
   task automatic cycle();
      int  q[$];
      int  g;
      bit  hit;
      @(posedge Clk);
      if (Reset) begin
         m_bus = '0; m_bus_h = '0; m_valid = 0; m_sel = 0; m_conf = 0;
         m_ptr = 0; m_cnt = 0; m_stky = 0;
      end else begin
         for (int i = 0; i < N; i++) if (gate[i]) q.push_back(i);
         m_conf = (q.size() > 1);
         if (q.size() == 0) begin
            m_valid = 0;
            m_bus   = '0;
         end else begin
            g = q[0];
            if (rr_mode) begin
               hit = 0;
               foreach (q[k]) if (!hit && q[k] >= m_ptr) begin g = q[k]; hit = 1; end
               m_ptr = (g + 1) % N;
            end
            m_valid = 1;
            m_sel   = g;
            m_bus   = src[g];
            m_bus_h = src[g];
         end
`ifdef BUS_CONFLICT_LOG_EN
         if (conflict_clr) begin
            m_cnt = 0; m_stky = 0;
         end else if (m_conf) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            m_stky = 1;
         end
`endif
      end
      #1;
   endtask

   task automatic rand_inputs(input bit allow_reset);
      for (int i = 0; i < N; i++) src[i] = W'($urandom);
      gate = N'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
      conflict_clr = ($urandom_range(0, 9) == 0);
      Reset = allow_reset && ($urandom_range(0, 19) == 0);
   endtask

   task automatic test_reset();
      Reset = 1; gate = '0; rr_mode = 0; conflict_clr = 0;
      for (int i = 0; i < N; i++) src[i] = W'($urandom);
      repeat (3) begin
         cycle();
         checks++;
         if (obs0 !== 23'h0 || obsh !== 23'h0) begin
            errors++;
            $display("FAIL reset_state obs=%h obsh=%h exp=0", obs0, obsh);
         end
      end
      Reset = 0;
      cycle();
      checks++;
      if (obs0 !== 23'h0 || obsh !== 23'h0) begin
         errors++;
         $display("FAIL reset_idle obs=%h obsh=%h exp=0", obs0, obsh);
      end
   endtask

   task automatic test_fixed();
      rr_mode = 0; gate = 4'b0110; src[1] = 16'h1234; src[2] = 16'hBEEF;
      cycle();
      checks++;
      if (bus0 !== 16'h1234 || sel0 !== 2'd1 || conf0 !== 1'b1 || valid0 !== 1'b1) begin
         errors++;
         $display("FAIL fixed_0110 bus=%h sel=%0d conf=%b valid=%b exp bus=1234 sel=1 conf=1 valid=1",
                  bus0, sel0, conf0, valid0);
      end
      repeat (30) begin
         rand_inputs(0);
         rr_mode = 0;
         cycle();
         checks++;
         if (obs0 !== exp_vec(m_bus) || obsh !== exp_vec(m_bus_h)) begin
            errors++;
            $display("FAIL fixed_rand obs=%h obsh=%h exp=%h exph=%h", obs0, obsh, exp_vec(m_bus), exp_vec(m_bus_h));
         end
      end
      conflict_clr = 0;
   endtask

   task automatic test_rr();
      int exp_seq[5] = '{0, 1, 2, 3, 0};
      Reset = 1; cycle(); Reset = 0;
      rr_mode = 1; gate = 4'b1111; conflict_clr = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++;
         if (sel0 !== 2'(exp_seq[i]) || obs0 !== exp_vec(m_bus)) begin
            errors++;
            $display("FAIL rr_1111[%0d] sel=%0d exp sel=%0d obs=%h exp=%h", i, sel0, exp_seq[i], obs0, exp_vec(m_bus));
         end
      end
      gate = 4'b1001;
      cycle();
      checks++;
      if (sel0 !== 2'd3 || valid0 !== 1'b1) begin
         errors++;
         $display("FAIL rr_1001 sel=%0d valid=%b exp sel=3 valid=1", sel0, valid0);
      end
      repeat (40) begin
         rand_inputs(0);
         rr_mode = 1;
         cycle();
         checks++;
         if (obs0 !== exp_vec(m_bus) || obsh !== exp_vec(m_bus_h)) begin
            errors++;
            $display("FAIL rr_rand obs=%h obsh=%h exp=%h exph=%h", obs0, obsh, exp_vec(m_bus), exp_vec(m_bus_h));
         end
      end
      conflict_clr = 0;
   endtask

   task automatic test_idle();
      rr_mode = 0; gate = 4'b0100; src[2] = 16'hBEEF;
      cycle();
      gate = 4'b0000;
      for (int i = 0; i < N; i++) src[i] = W'($urandom);
      repeat (2) begin
         cycle();
         checks++;
         if (bush !== 16'hBEEF || validh !== 1'b0 || selh !== 2'd2) begin
            errors++;
            $display("FAIL idle_hold bus=%h valid=%b sel=%0d exp bus=beef valid=0 sel=2", bush, validh, selh);
         end
         checks++;
         if (bus0 !== 16'h0 || valid0 !== 1'b0 || sel0 !== 2'd2) begin
            errors++;
            $display("FAIL idle_zero bus=%h valid=%b sel=%0d exp bus=0 valid=0 sel=2", bus0, valid0, sel0);
         end
      end
   endtask

   task automatic test_conflict_log();
      logic [CW-1:0] exp_cnt;
      logic          exp_stky;
      Reset = 1; cycle(); Reset = 0;
      gate = 4'b1111; conflict_clr = 0;
      repeat (5) begin
         for (int i = 0; i < N; i++) src[i] = W'($urandom);
         cycle();
      end
`ifdef BUS_CONFLICT_LOG_EN
      exp_cnt = 2'd3; exp_stky = 1'b1;
`else
      exp_cnt = 2'd0; exp_stky = 1'b0;
`endif
      checks++;
      if (cnt0 !== exp_cnt || stky0 !== exp_stky || conf0 !== 1'b1 || obs0 !== exp_vec(m_bus)) begin
         errors++;
         $display("FAIL conflict_sat cnt=%0d stky=%b conf=%b exp cnt=%0d stky=%b conf=1", cnt0, stky0, conf0, exp_cnt, exp_stky);
      end
      conflict_clr = 1;
      cycle();
      conflict_clr = 0;
      checks++;
      if (cnt0 !== 2'd0 || stky0 !== 1'b0 || conf0 !== 1'b1 || cnth !== 2'd0 || stkyh !== 1'b0) begin
         errors++;
         $display("FAIL conflict_clr cnt=%0d stky=%b conf=%b exp cnt=0 stky=0 conf=1", cnt0, stky0, conf0);
      end
   endtask

   task automatic test_reset_mid();
      Reset = 1; cycle(); Reset = 0;
      rr_mode = 1; gate = 4'b0010;
      cycle();
      gate = 4'b1111; Reset = 1;
      cycle();
      checks++;
      if (obs0 !== 23'h0 || obsh !== 23'h0) begin
         errors++;
         $display("FAIL reset_mid obs=%h obsh=%h exp=0", obs0, obsh);
      end
      Reset = 0;
      cycle();
      checks++;
      if (sel0 !== 2'd0 || valid0 !== 1'b1 || obs0 !== exp_vec(m_bus)) begin
         errors++;
         $display("FAIL reset_release sel=%0d valid=%b exp sel=0 valid=1", sel0, valid0);
      end
   endtask

   task automatic test_random();
      repeat (300) begin
         rand_inputs(1);
         cycle();
         checks++;
         if (obs0 !== exp_vec(m_bus) || obsh !== exp_vec(m_bus_h)) begin
            errors++;
            $display("FAIL random obs=%h obsh=%h exp=%h exph=%h", obs0, obsh, exp_vec(m_bus), exp_vec(m_bus_h));
         end
      end
      Reset = 0; conflict_clr = 0;
   endtask

   initial begin
      Reset = 1; gate = '0; rr_mode = 0; conflict_clr = 0; src = '0;
      m_bus = '0; m_bus_h = '0; m_valid = 0; m_sel = 0; m_conf = 0;
      m_ptr = 0; m_cnt = 0; m_stky = 0;
      test_reset();
      test_fixed();
      test_rr();
      test_idle();
      test_conflict_log();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
